// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the decode-stage hazard scoreboard.
//   REG_W     : register specifier width
//   NUM_REGS  : architectural register count (2**REG_W)
//   slot_t    : one tracked in-flight instruction {valid, dest, is_load}
//   SLOT_EMPTY: an invalid slot (bubble)
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_W    = 3;
  localparam int NUM_REGS = 2 ** REG_W;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_slot_cmp.sv
// -----------------------------------------------------------------------------
// hazard_slot_cmp
//   Compares one in-flight slot against the two ID source specifiers.
//   Parameter LOAD_ONLY: when set, only a load in this slot can match
//   (used when forwarding covers every non-load producer).
// Ports:
//   slot  in  slot_t  tracked in-flight instruction
//   src1  in  REG_W   first ID source specifier
//   src2  in  REG_W   second ID source specifier
//   hit1  out 1       slot writes src1
//   hit2  out 1       slot writes src2
// -----------------------------------------------------------------------------
module hazard_slot_cmp
  import hazard_pkg::*;
#(
  parameter bit LOAD_ONLY = 1'b0
) (
  input  slot_t            slot,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  output logic             hit1,
  output logic             hit2
);

  logic live;

  // R0 is an ordinary register, so a zero specifier is compared like any other.
  assign live = slot.valid & (!LOAD_ONLY || slot.is_load);
  assign hit1 = live & (slot.dest == src1);
  assign hit2 = live & (slot.dest == src2);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Decode-stage RAW hazard unit. Tracks destinations of in-flight
//   instructions (slot0=EX, slot1=MEM, ...) in a shift pipeline and raises
//   stall when an ID source depends on a write that has not reached WB.
//   WB is not tracked: the register file writes before it reads.
//
//   Build option: define HAZARD_FWD_EN when the datapath forwards EX/MEM and
//   MEM/WB results into EX. Then only a load in slot0 can stall (load-use,
//   at most one cycle). pending_mask still reports every valid slot.
//
//   Stall protocol: stall is combinational from the ID fields and slot state.
//   While stall=1 the pipeline holds PC and IF/ID and a bubble enters ID/EX;
//   the ID instruction is accepted (enters slot0) on the first edge where
//   stall=0 and flush=0. flush kills the ID instruction and overrides stall.
//
// Parameters:
//   DEPTH  number of tracked slots, 1..4
//   CNT_W  stall counter width
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_rd1_en/2_en  source reads enabled
//   id_readReg1/2   source specifiers
//   id_wr_en        instruction writes id_writeReg
//   id_writeReg     destination specifier
//   id_is_load      instruction is a load
//   flush           kill the ID instruction this cycle
//   stall           hold PC and IF/ID, bubble ID/EX
//   ex_bubble       slot0 holds an injected bubble
//   pending_mask    bit r set when any valid slot targets register r
//   stall_count     saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_rd1_en,
  input  logic                id_rd2_en,
  input  logic [REG_W-1:0]    id_readReg1,
  input  logic [REG_W-1:0]    id_readReg2,
  input  logic                id_wr_en,
  input  logic [REG_W-1:0]    id_writeReg,
  input  logic                id_is_load,
  input  logic                flush,
  output logic                stall,
  output logic                ex_bubble,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    stall_count
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH must be in 1..4");
  end

`ifdef HAZARD_FWD_EN
  // Forwarding resolves everything except a load still in EX.
  localparam bit               LOAD_ONLY = 1'b1;
  localparam logic [DEPTH-1:0] CMP_MASK  = DEPTH'(1);
`else
  localparam bit               LOAD_ONLY = 1'b0;
  localparam logic [DEPTH-1:0] CMP_MASK  = {DEPTH{1'b1}};
`endif

  slot_t            slots [DEPTH];
  slot_t            new_slot;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic             match1;
  logic             match2;
  logic             raw;
  logic             issue;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    hazard_slot_cmp #(
      .LOAD_ONLY (LOAD_ONLY)
    ) u_cmp (
      .slot (slots[i]),
      .src1 (id_readReg1),
      .src2 (id_readReg2),
      .hit1 (hit1[i]),
      .hit2 (hit2[i])
    );
  end

  // Only slots already in flight are compared, so an instruction never
  // matches its own destination (ADD R1,R1,R1 is not a self-hazard).
  assign match1 = |(hit1 & CMP_MASK);
  assign match2 = |(hit2 & CMP_MASK);
  assign raw    = id_valid & ((id_rd1_en & match1) | (id_rd2_en & match2));
  assign stall  = raw & ~flush;
  assign issue  = id_valid & id_wr_en & ~stall & ~flush;

  always_comb begin
    new_slot = SLOT_EMPTY;
    if (issue) begin
      new_slot.valid   = 1'b1;
      new_slot.dest    = id_writeReg;
      new_slot.is_load = id_is_load;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].valid) begin
        pending_mask[slots[i].dest] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= SLOT_EMPTY;
      end
    end else begin
      slots[0] <= new_slot;
      for (int i = 1; i < DEPTH; i++) begin
        slots[i] <= slots[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_bubble   <= 1'b0;
      stall_count <= '0;
    end else begin
      ex_bubble <= stall;
      // Saturate rather than wrap so long runs stay visibly large.
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Expected stall cycles for a back-to-back dependent pair.
  localparam int NS_ALU  = FWD ? 0 : 2;
  localparam int NS_LOAD = FWD ? 1 : 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                id_valid, id_rd1_en, id_rd2_en, id_wr_en, id_is_load, flush;
  logic [REG_W-1:0]    id_readReg1, id_readReg2, id_writeReg;
  logic                stall, ex_bubble, stall_s, ex_bubble_s;
  logic [NUM_REGS-1:0] pending_mask, pending_mask_s;
  logic [15:0]         stall_count;
  logic [1:0]          stall_count_s;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.DEPTH(2), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_rd1_en (id_rd1_en),
    .id_rd2_en (id_rd2_en), .id_readReg1 (id_readReg1), .id_readReg2 (id_readReg2),
    .id_wr_en (id_wr_en), .id_writeReg (id_writeReg), .id_is_load (id_is_load),
    .flush (flush), .stall (stall), .ex_bubble (ex_bubble),
    .pending_mask (pending_mask), .stall_count (stall_count)
  );

  // Narrow-counter copy on the same stimulus for the saturation scenario.
  hazard_scoreboard #(.DEPTH(2), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_rd1_en (id_rd1_en),
    .id_rd2_en (id_rd2_en), .id_readReg1 (id_readReg1), .id_readReg2 (id_readReg2),
    .id_wr_en (id_wr_en), .id_writeReg (id_writeReg), .id_is_load (id_is_load),
    .flush (flush), .stall (stall_s), .ex_bubble (ex_bubble_s),
    .pending_mask (pending_mask_s), .stall_count (stall_count_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic r1e, input logic r2e,
                       input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                       input logic we, input logic [REG_W-1:0] wr,
                       input logic ld, input logic fl);
    id_valid    = v;
    id_rd1_en   = r1e;
    id_rd2_en   = r2e;
    id_readReg1 = r1;
    id_readReg2 = r2;
    id_wr_en    = we;
    id_writeReg = wr;
    id_is_load  = ld;
    flush       = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_ex_bubble got=%b exp=0", ex_bubble); end
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending_mask); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0000", stall_count); end
  endtask

  // ADD R3 then SUB R4 <- R3
  task automatic test_alu_dep();
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_prod_stall got=%b exp=0", stall); end
    for (int c = 0; c <= NS_ALU; c++) begin
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0); #1;
      checks++; if (stall !== (c < NS_ALU)) begin errors++; $display("FAIL alu_stall c=%0d got=%b exp=%b", c, stall, (c < NS_ALU)); end
      checks++; if (ex_bubble !== (c > 0)) begin errors++; $display("FAIL alu_ex_bubble c=%0d got=%b exp=%b", c, ex_bubble, (c > 0)); end
      if (c == 0) begin
        checks++; if (pending_mask !== 8'h08) begin errors++; $display("FAIL alu_pending got=%h exp=08", pending_mask); end
      end
    end
    @(negedge clk); drive_idle(); #1;
    checks++; if (ex_bubble !== 1'b0) begin errors++; $display("FAIL alu_after_bubble got=%b exp=0", ex_bubble); end
    checks++; if (stall_count !== 16'(NS_ALU)) begin errors++; $display("FAIL alu_count got=%0d exp=%0d", stall_count, NS_ALU); end
    checks++;
    if (pending_mask !== ((NS_ALU > 0) ? 8'h10 : 8'h18)) begin
      errors++; $display("FAIL alu_issue_pending got=%h exp=%h", pending_mask, ((NS_ALU > 0) ? 8'h10 : 8'h18));
    end
  endtask

  // LD R2 then ADD R5 <- ?, R2
  task automatic test_load_use();
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
    for (int c = 0; c <= NS_LOAD; c++) begin
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 3'd7, 3'd2, 1'b1, 3'd5, 1'b0, 1'b0); #1;
      checks++; if (stall !== (c < NS_LOAD)) begin errors++; $display("FAIL ld_stall c=%0d got=%b exp=%b", c, stall, (c < NS_LOAD)); end
      if (c == 0) begin
        checks++; if (pending_mask !== 8'h04) begin errors++; $display("FAIL ld_pending got=%h exp=04", pending_mask); end
      end
    end
    @(negedge clk); drive_idle(); #1;
    checks++; if (stall_count !== 16'(NS_LOAD)) begin errors++; $display("FAIL ld_count got=%0d exp=%0d", stall_count, NS_LOAD); end
  endtask

  // R0 is an ordinary register; disabled reads never stall.
  task automatic test_r0();
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL r0_stall got=%b exp=1", stall); end
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_disabled_rd1 got=%b exp=0", stall); end
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_disabled_both got=%b exp=0", stall); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 3'd6, 1'b0, 1'b1); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (pending_mask !== 8'h20) begin errors++; $display("FAIL flush_no_insert got=%h exp=20", pending_mask); end
    checks++; if (ex_bubble !== 1'b0) begin errors++; $display("FAIL flush_ex_bubble got=%b exp=0", ex_bubble); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL flush_count got=%0d exp=0", stall_count); end
  endtask

  // Four load-use pairs through a 2-bit counter: must stop at 3.
  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'(k), 1'b1, 1'b0);
      for (int c = 0; c <= NS_LOAD; c++) begin
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'(k), 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      end
      if (k == 1) begin
        #1;
        checks++; if (stall_count_s !== 2'(NS_LOAD)) begin errors++; $display("FAIL sat_first got=%0d exp=%0d", stall_count_s, NS_LOAD); end
      end
    end
    @(negedge clk); drive_idle(); #1;
    checks++; if (stall_count_s !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", stall_count_s); end
    checks++; if (stall_count !== 16'(4 * NS_LOAD)) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", stall_count, 4 * NS_LOAD); end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall got=%b exp=1", stall); end
    @(posedge clk); #2;
    checks++; if (ex_bubble !== 1'b1) begin errors++; $display("FAIL ar_pre_bubble got=%b exp=1", ex_bubble); end
    rst = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall got=%b exp=0", stall); end
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL ar_pending got=%h exp=00", pending_mask); end
    checks++; if (ex_bubble !== 1'b0) begin errors++; $display("FAIL ar_bubble got=%b exp=0", ex_bubble); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL ar_count got=%0d exp=0", stall_count); end
    #1; rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_post_stall got=%b exp=0", stall); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (pending_mask !== 8'h80) begin errors++; $display("FAIL ar_post_issue got=%h exp=80", pending_mask); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Self-dependence with empty pipeline: no stall.
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 3'd1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL self_dep got=%b exp=0", stall); end
    // id_valid=0 never stalls and inserts nothing.
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 3'd2, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_stall got=%b exp=0", stall); end
    checks++; if (pending_mask !== 8'h02) begin errors++; $display("FAIL invalid_pending got=%h exp=02", pending_mask); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (pending_mask !== 8'h02) begin errors++; $display("FAIL invalid_no_insert got=%h exp=02", pending_mask); end
    // Same register on both sources behaves as one source.
    do_reset();
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0);
    for (int c = 0; c <= NS_LOAD; c++) begin
      @(negedge clk); drive(1'b1, 1'b1, 1'b1, 3'd6, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0); #1;
      checks++; if (stall !== (c < NS_LOAD)) begin errors++; $display("FAIL both_src c=%0d got=%b exp=%b", c, stall, (c < NS_LOAD)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_alu_dep();
    test_load_use();
    test_r0();
    test_flush();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-stage data-hazard unit. Sits directly downstream of the register-specifier decoder.
- Consumes that decoder's readReg1/readReg2/writeReg plus per-instruction enables.
- Tracks destination registers of in-flight instructions (EX, MEM, ...) in a shift pipeline and raises stall when an ID source depends on an unretired write.
- Pipeline control uses stall to freeze PC/IF-ID and inject a bubble into ID/EX.

Parameters:
- DEPTH, 2, number of tracked in-flight slots compared against ID sources (slot0=EX, slot1=MEM); legal 1..4. WB is exempt because the register file bypasses write-before-read.
- REG_W, 3, register specifier width.
- NUM_REGS, 8, architectural register count (2**REG_W).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rd1_en  in  1  instruction reads readReg1
- id_rd2_en  in  1  instruction reads readReg2
- id_readReg1  in  REG_W  first source specifier
- id_readReg2  in  REG_W  second source specifier
- id_wr_en  in  1  instruction writes writeReg
- id_writeReg  in  REG_W  destination specifier
- id_is_load  in  1  instruction is LD (result available after MEM)
- flush  in  1  branch/jump resolved taken; kills ID instruction this cycle
- stall  out  1  combinational; hold PC and IF/ID, bubble ID/EX
- ex_bubble  out  1  registered; slot0 holds an injected bubble
- pending_mask  out  NUM_REGS  combinational; bit r set if any valid slot targets register r
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Slot contents: {valid, dest[REG_W-1:0], is_load}.
- Reset (asynchronous, immediate): all slots invalid, ex_bubble=0, stall_count=0. As a result, stall=0 and pending_mask=0 at once, including when reset is asserted mid-stall.
- match(r) = OR over i<DEPTH of (slot[i].valid & slot[i].dest==r).
- R0 is a real register with no hardwired zero; matches on r=0 count.
- raw = id_valid & ((id_rd1_en & match(id_readReg1)) | (id_rd2_en & match(id_readReg2))).
- stall = raw & ~flush. Flush wins because the ID instruction is being killed.
- Each rising clk edge:
  - slot[i+1] <= slot[i] for i<DEPTH-1; the oldest slot drops off.
  - slot0 <= {1, id_writeReg, id_is_load} when id_valid & id_wr_en & ~stall & ~flush; otherwise slot0 is invalid.
  - ex_bubble <= stall.
  - stall_count <= stall_count+1 when stall and stall_count != all-ones; otherwise hold. It saturates and never wraps.
- Latency: a dependent instruction stalls while the producer is in EX or MEM. It issues on the cycle the producer leaves slot DEPTH-1, giving DEPTH stall cycles for back-to-back dependence.
- Same register on both sources gives the same result as one source. A self-dependence (e.g. ADD R1,R1,R1) matches only older slots, never its own ID write.
- id_valid=0 gives stall=0 and inserts no slot.
- Disabled reads (e.g. J, LBI sources) never stall, even when the specifier field matches.
- Simultaneous stall and flush: flush wins; no slot is inserted; the counter does not increment.
- Invalid DEPTH is a compile-time error.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- With the macro defined, EX/MEM-to-EX and MEM/WB-to-EX forwarding exists, so only load-use stalls:
  - match(r) = slot0.valid & slot0.is_load & slot0.dest==r.
  - Maximum one stall cycle.
  - pending_mask is unchanged (all valid slots).
- Without the macro, behaviour is the full compare above (no forwarding).

Decomposition:
- Package hazard_pkg:
  - REG_W and NUM_REGS localparams.
  - typedef slot_t {logic valid; logic [REG_W-1:0] dest; logic is_load}.
  - SLOT_EMPTY constant.
- Sub-module hazard_slot_cmp: one per slot; takes a slot_t and two source specifiers, returns two match bits. The top ORs the results and owns the shift register and counter.

Test Plan:
- ADD R3 (wr R3) then next cycle SUB reading R3 (rd1_en=1) -> stall=1 for 2 cycles (DEPTH=2), ex_bubble=1 the cycle after each stall, SUB issues cycle 3, stall_count=2. With HAZARD_FWD_EN: stall=0.
- LD R2 then ADD reading R2 on readReg2 -> stall=1 exactly 1 cycle with HAZARD_FWD_EN, 2 cycles without. pending_mask=8'b0000_0100 while LD is in slot0.
- Producer writes R0, consumer reads R0 -> stall asserted (R0 not special). Consumer with rd1_en=0 and readReg1=0 -> stall=0.
- Dependent instruction stalled in ID, flush=1 same cycle -> stall=0, slot0 invalid next cycle, stall_count unchanged.
- Force stall_count to 16'hFFFE, hold a hazard 3 cycles -> count reaches 16'hFFFF and stays.
- Assert rst asynchronously between edges during a stall -> stall, pending_mask, ex_bubble, and stall_count all 0 before the next clk edge. The first post-reset instruction issues without stall.
